// File: rtl/trigger_capture_buffer.sv
// Pre/post-trigger sample capture into a circular RAM, then byte-serial readout
// of the whole buffer (oldest word first) over a request/loaded UART handshake.
module trigger_capture_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned PRE_TRIG   = 128
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] SampleIn,
    input  logic                  SampleValid,
    input  logic                  Arm,
    input  logic                  Trigger,
    input  logic                  Abort,
    output logic [7:0]            TxData,
    output logic                  TxRequestToSend,
    input  logic                  TxDataLoaded,
    output logic                  Armed,
    output logic                  Busy,
    output logic                  Done
);

    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam int unsigned BYTES     = (DATA_WIDTH + 7) / 8;
    localparam int unsigned PAD_WIDTH = BYTES * 8;

    localparam logic [ADDR_WIDTH-1:0] PRE_MAX   = ADDR_WIDTH'(PRE_TRIG);
    localparam logic [ADDR_WIDTH-1:0] POST_MAX  = ADDR_WIDTH'(DEPTH - PRE_TRIG);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [3:0]            LAST_BYTE = 4'(BYTES - 1);

    typedef enum logic [1:0] {StIdle, StPreTrig, StPostTrig, StReadout} state_e;
    typedef enum logic [1:0] {PhFetch, PhLoad, PhSend, PhGap} phase_e;

    state_e                state_q, state_d;
    phase_e                phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_WIDTH-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [3:0]            byte_idx_q, byte_idx_d;
    logic [PAD_WIDTH-1:0]  word_q, word_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  rts_q, rts_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] post_inc;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [PAD_WIDTH-1:0]  ram_pad;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Single-port RAM, registered read; no writes happen during readout.
    always_ff @(posedge Clock) begin
        if (ram_we) begin
            mem[ram_addr] <= SampleIn;
        end
        ram_rdata <= mem[ram_addr];
    end

    assign ram_pad         = PAD_WIDTH'(ram_rdata);
    assign Armed           = (state_q == StPreTrig) && (pre_cnt_q == PRE_MAX);
    assign Busy            = (state_q != StIdle);
    assign Done            = done_q;
    assign TxData          = tx_data_q;
    assign TxRequestToSend = rts_q;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pre_cnt_d  = pre_cnt_q;
        post_cnt_d = post_cnt_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        tx_data_d  = tx_data_q;
        rts_d      = rts_q;
        done_d     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = wr_ptr_q;
        post_inc   = post_cnt_q + ADDR_WIDTH'(SampleValid);

        unique case (state_q)
            StIdle: begin
                if (Arm) begin
                    state_d    = StPreTrig;
                    wr_ptr_d   = '0;
                    pre_cnt_d  = '0;
                    post_cnt_d = '0;
                end
            end
            StPreTrig, StPostTrig: begin
                if (SampleValid) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (pre_cnt_q != PRE_MAX) begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end
                end
                if (state_q == StPostTrig || (Armed && Trigger)) begin
                    state_d    = StPostTrig;
                    post_cnt_d = post_inc;
                    // Write pointer now addresses the oldest word in the ring.
                    if (post_inc == POST_MAX) begin
                        state_d    = StReadout;
                        phase_d    = PhFetch;
                        rd_ptr_d   = wr_ptr_d;
                        word_cnt_d = '0;
                    end
                end
            end
            StReadout: begin
                ram_addr = rd_ptr_q;
                unique case (phase_q)
                    PhFetch: phase_d = PhLoad;
                    PhLoad: begin
                        tx_data_d  = ram_pad[7:0];
                        word_d     = ram_pad >> 8;
                        rts_d      = 1'b1;
                        byte_idx_d = '0;
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        phase_d    = PhSend;
                    end
                    PhSend: begin
                        if (TxDataLoaded) begin
                            rts_d = 1'b0;
                            if (byte_idx_q != LAST_BYTE) begin
                                byte_idx_d = byte_idx_q + 4'd1;
                                phase_d    = PhGap;
                            end else if (word_cnt_q == LAST_WORD) begin
                                done_d  = 1'b1;
                                state_d = StIdle;
                            end else begin
                                word_cnt_d = word_cnt_q + 1'b1;
                                phase_d    = PhFetch;
                            end
                        end
                    end
                    PhGap: begin
                        tx_data_d = word_q[7:0];
                        word_d    = word_q >> 8;
                        rts_d     = 1'b1;
                        phase_d   = PhSend;
                    end
                    default: phase_d = PhFetch;
                endcase
            end
            default: state_d = StIdle;
        endcase

        if (Abort) begin
            state_d = StIdle;
            phase_d = PhFetch;
            rts_d   = 1'b0;
            done_d  = 1'b0;
            ram_we  = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            phase_q    <= PhFetch;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            tx_data_q  <= '0;
            rts_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pre_cnt_q  <= pre_cnt_d;
            post_cnt_q <= post_cnt_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            tx_data_q  <= tx_data_d;
            rts_q      <= rts_d;
            done_q     <= done_d;
        end
    end

endmodule
